// File: rtl/audio_pkg.sv
// Shared audio-path definitions: ADSR state encoding.
package audio_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

endpackage

// File: rtl/adsr_sat_step.sv
// Saturating add/sub of an ACCW-bit accumulator toward a clamp bound.
module adsr_sat_step #(
   parameter int ACCW = 24
) (
   input  logic [ACCW-1:0] a,
   input  logic [ACCW-1:0] b,
   input  logic [ACCW-1:0] bound,
   input  logic            sub,
   output logic [ACCW-1:0] y,
   output logic            hit
);

   logic [ACCW:0] sum;
   logic [ACCW:0] diff;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      // diff MSB set means the subtraction went below zero
      if (sub) begin
         hit = diff[ACCW] || (diff[ACCW-1:0] <= bound);
         y   = hit ? bound : diff[ACCW-1:0];
      end else begin
         hit = sum >= {1'b0, bound};
         y   = hit ? bound : sum[ACCW-1:0];
      end
   end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope, one update per sample_tick.
// Define ADSR_EXP_RELEASE_EN for an exponential release curve.
module adsr_envelope
   import audio_pkg::*;
#(
   parameter int BITSIZE   = 16,
   parameter int ACCW      = 24,
   parameter int EXP_SHIFT = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_tick,
   input  logic                 gate,
   input  logic [ACCW-1:0]      attack_rate,
   input  logic [ACCW-1:0]      decay_rate,
   input  logic [ACCW-1:0]      release_rate,
   input  logic [BITSIZE-2:0]   sustain_level,
   output logic [BITSIZE-1:0]   env,
   output logic                 env_valid,
   output logic [STATE_W-1:0]   state,
   output logic                 busy
);

   if (ACCW < BITSIZE + 1 || EXP_SHIFT >= ACCW) begin : g_bad_cfg
      $error("adsr_envelope: invalid ACCW/BITSIZE/EXP_SHIFT");
   end

   localparam logic [ACCW-1:0] MAX = '1;

   state_t          st;
   logic [ACCW-1:0] acc;
   logic            tick_d;
   logic [ACCW-1:0] target;
   logic [ACCW-1:0] rel_step;
   logic [ACCW-1:0] op_b;
   logic [ACCW-1:0] bound;
   logic            sub;
   logic [ACCW-1:0] nxt;
   logic            hit;

   assign target = {sustain_level, {(ACCW-BITSIZE+1){1'b0}}};

`ifdef ADSR_EXP_RELEASE_EN
   assign rel_step = (acc >> EXP_SHIFT) | ACCW'(1);
`else
   assign rel_step = release_rate;
`endif

   always_comb begin
      op_b  = attack_rate;
      bound = MAX;
      sub   = 1'b0;
      case (st)
         S_DECAY: begin
            op_b  = decay_rate;
            bound = target;
            sub   = 1'b1;
         end
         S_RELEASE: begin
            op_b  = rel_step;
            bound = '0;
            sub   = 1'b1;
         end
         default: ;
      endcase
   end

   adsr_sat_step #(.ACCW(ACCW)) u_step (
      .a     (acc),
      .b     (op_b),
      .bound (bound),
      .sub   (sub),
      .y     (nxt),
      .hit   (hit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= S_IDLE;
         acc       <= '0;
         tick_d    <= 1'b0;
         env       <= '0;
         env_valid <= 1'b0;
      end else begin
         tick_d    <= sample_tick;
         env_valid <= tick_d;
         if (tick_d) env <= {1'b0, acc[ACCW-1 -: BITSIZE-1]};
         if (sample_tick) begin
            case (st)
               S_IDLE: begin
                  acc <= '0;
                  if (gate) st <= S_ATTACK;
               end
               S_ATTACK: begin
                  if (!gate) st <= S_RELEASE;
                  else begin
                     acc <= nxt;
                     if (hit) st <= S_DECAY;
                  end
               end
               S_DECAY: begin
                  if (!gate) st <= S_RELEASE;
                  else begin
                     acc <= nxt;
                     if (hit) st <= S_SUSTAIN;
                  end
               end
               S_SUSTAIN: begin
                  if (!gate) st <= S_RELEASE;
                  else acc <= target;
               end
               S_RELEASE: begin
                  // retrigger keeps the current level
                  if (gate) st <= S_ATTACK;
                  else begin
                     acc <= nxt;
                     if (hit) st <= S_IDLE;
                  end
               end
               default: begin
                  st  <= S_IDLE;
                  acc <= '0;
               end
            endcase
         end
      end
   end

   assign state = st;
   assign busy  = (st != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed table-driven bench for adsr_envelope (ACCW=24, BITSIZE=16).
module tb_adsr_envelope;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_tick;
   logic        gate;
   logic [23:0] attack_rate;
   logic [23:0] decay_rate;
   logic [23:0] release_rate;
   logic [14:0] sustain_level;
   logic [15:0] env;
   logic        env_valid;
   logic [2:0]  state;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   adsr_envelope #(.BITSIZE(16), .ACCW(24), .EXP_SHIFT(9)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_tick   (sample_tick),
      .gate          (gate),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .release_rate  (release_rate),
      .sustain_level (sustain_level),
      .env           (env),
      .env_valid     (env_valid),
      .state         (state),
      .busy          (busy)
   );

   typedef struct {
      int          reps;
      logic        g;
      logic [23:0] ar;
      logic [23:0] dr;
      logic [23:0] rr;
      logic [14:0] sl;
      logic [2:0]  st;
      logic [15:0] e;
      logic        b;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   // one tick per 4 clk; env_valid must be high exactly one cycle
   task automatic tick();
      logic v1, v2;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      @(negedge clk);
      v1 = env_valid;
      @(negedge clk);
      v2 = env_valid;
      @(negedge clk);
      chk("valid_pulse", {30'd0, v1, v2}, 32'd2);
   endtask

   task automatic add(input int n, input logic g, input logic [23:0] ar,
                      input logic [23:0] dr, input logic [23:0] rr,
                      input logic [14:0] sl, input logic [2:0] st,
                      input logic [15:0] e, input logic b);
      vec_t v;
      v.reps = n; v.g = g; v.ar = ar; v.dr = dr; v.rr = rr;
      v.sl = sl; v.st = st; v.e = e; v.b = b;
      tbl.push_back(v);
   endtask

   task automatic chk_out(input string nm, input logic [2:0] st,
                          input logic [15:0] e, input logic b);
      chk({nm, "_state"}, {29'd0, state}, {29'd0, st});
      chk({nm, "_env"}, {16'd0, env}, {16'd0, e});
      chk({nm, "_busy"}, {31'd0, busy}, {31'd0, b});
   endtask

   function automatic logic [15:0] env_of(input logic [23:0] a);
      return {1'b0, a[23:9]};
   endfunction

   localparam logic [23:0] A = 24'h100000;
   localparam logic [23:0] D = 24'h080000;
   localparam logic [23:0] R = 24'h100000;

   initial begin
      logic [23:0] m;
      logic [23:0] stp;
      logic [15:0] e_exp;
      int          b0;
      bit          done;

      rst_n = 1'b0; sample_tick = 1'b0; gate = 1'b0;
      attack_rate = '0; decay_rate = '0; release_rate = '0;
      sustain_level = '0;
      repeat (2) @(negedge clk);
      chk_out("rst0", 3'd0, 16'h0000, 1'b0);
      chk("rst0_valid", {31'd0, env_valid}, 32'd0);
      rst_n = 1'b1;

      gate = 1'b1; attack_rate = A;
      repeat (4) tick();
      chk_out("pre_rst", 3'd1, 16'h1800, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_out("rst_mid", 3'd0, 16'h0000, 1'b0);
      chk("rst_mid_valid", {31'd0, env_valid}, 32'd0);

      add(1,  1, A, D, R, 15'h4000, 3'd1, 16'h0000, 1);
      add(1,  1, A, D, R, 15'h4000, 3'd1, 16'h0800, 1);
      add(14, 1, A, D, R, 15'h4000, 3'd1, 16'h7800, 1);
      add(1,  1, A, D, R, 15'h4000, 3'd2, 16'h7FFF, 1);
      add(1,  1, A, D, R, 15'h4000, 3'd2, 16'h7BFF, 1);
      add(14, 1, A, D, R, 15'h4000, 3'd2, 16'h43FF, 1);
      add(1,  1, A, D, R, 15'h4000, 3'd3, 16'h4000, 1);
      add(1,  1, A, D, R, 15'h2000, 3'd3, 16'h2000, 1);
      add(1,  0, A, D, R, 15'h2000, 3'd4, 16'h2000, 1);
`ifndef ADSR_EXP_RELEASE_EN
      add(3,  0, A, D, R, 15'h2000, 3'd4, 16'h0800, 1);
      add(1,  0, A, D, R, 15'h2000, 3'd0, 16'h0000, 0);
      add(1,  1, A, D, R, 15'h2000, 3'd1, 16'h0000, 1);
      add(2,  1, A, D, R, 15'h2000, 3'd1, 16'h1000, 1);
      add(1,  0, A, D, R, 15'h2000, 3'd4, 16'h1000, 1);
      add(1,  1, A, D, R, 15'h2000, 3'd1, 16'h1000, 1);
      add(1,  1, A, D, R, 15'h2000, 3'd1, 16'h1800, 1);
      add(3,  1, 0, D, R, 15'h2000, 3'd1, 16'h1800, 1);
      add(1,  0, 0, D, 0, 15'h2000, 3'd4, 16'h1800, 1);
      add(3,  0, 0, D, 0, 15'h2000, 3'd4, 16'h1800, 1);
      add(3,  0, 0, D, R, 15'h2000, 3'd0, 16'h0000, 0);
`endif

      foreach (tbl[i]) begin
         gate = tbl[i].g;
         attack_rate = tbl[i].ar;
         decay_rate = tbl[i].dr;
         release_rate = tbl[i].rr;
         sustain_level = tbl[i].sl;
         repeat (tbl[i].reps) tick();
         chk_out($sformatf("v%0d", i), tbl[i].st, tbl[i].e, tbl[i].b);
      end

`ifdef ADSR_EXP_RELEASE_EN
      m = 24'h400000;
      done = 1'b0;
      b0 = bad;
      for (int k = 0; k < 8000 && !done && bad == b0; k++) begin
         stp = (m >> 9) | 24'd1;
         m = (stp >= m) ? 24'd0 : m - stp;
         tick();
         chk("exp_env", {16'd0, env}, {16'd0, env_of(m)});
         if (m == 24'd0) begin
            chk_out("exp_idle", 3'd0, 16'h0000, 1'b0);
            done = 1'b1;
         end
      end
      if (!done && bad == b0) begin
         bad++;
         $display("FAIL exp_timeout: got busy=%0d want idle", busy);
      end
`endif

      gate = 1'b1; sustain_level = 15'h7FFF;
      attack_rate = 24'hFFFFFF; decay_rate = 24'h0001FF;
      release_rate = R;
      tick();
      chk_out("fs_att", 3'd1, 16'h0000, 1'b1);
      tick();
      chk_out("fs_sat", 3'd2, 16'h7FFF, 1'b1);
      gate = 1'b0;
      tick();
      chk_out("fs_rel", 3'd4, 16'h7FFF, 1'b1);
      tick();
`ifdef ADSR_EXP_RELEASE_EN
      e_exp = 16'h7FC0;
`else
      e_exp = 16'h77FF;
`endif
      chk_out("fs_step", 3'd4, e_exp, 1'b1);
      gate = 1'b1;
      tick();
      chk_out("fs_retrig", 3'd1, e_exp, 1'b1);
      tick();
      chk_out("fs_resat", 3'd2, 16'h7FFF, 1'b1);
      tick();
      chk_out("fs_sus_eq", 3'd3, 16'h7FFF, 1'b1);

      @(negedge clk);
      gate = 1'b0;
      @(negedge clk);
      gate = 1'b1;
      tick();
      chk_out("glitch", 3'd3, 16'h7FFF, 1'b1);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_out("rst_end", 3'd0, 16'h0000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
